cursor_select_ctrl: RTL and testbench

CURSOR_SELECT_CTRL -- requirements
Module: cursor_select_ctrl

---
 rtl/chess_pkg.sv | 16 +
 rtl/cursor_axis_step.sv | 29 ++
 rtl/cursor_select_ctrl.sv | 122 ++++++++++++
 tb/tb_cursor_select_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared types and constants for the board cursor / move-selection logic.
package chess_pkg;

   localparam int COORD_W = 3;

   typedef logic [COORD_W-1:0] coord_t;

   localparam coord_t BOARD_MAX = 3'd7;

   typedef enum logic [1:0] {
      SELECT_SRC = 2'd0,
      SELECT_DST = 2'd1,
      MOVE_PEND  = 2'd2
   } sel_state_t;

endpackage

// File: rtl/cursor_axis_step.sv
// One-axis cursor step: +1 / -1 with edge wrap when CURSOR_WRAP_EN is defined,
// otherwise saturating at 0 and BOARD_MAX (pulses at the edge are ignored).
module cursor_axis_step
   import chess_pkg::*;
(
   input  coord_t coord,
   input  logic   inc,
   input  logic   dec,
   output coord_t coord_nxt
);

   always_comb begin
      coord_nxt = coord;
`ifdef CURSOR_WRAP_EN
      if (inc) begin
         coord_nxt = (coord == BOARD_MAX) ? coord_t'(0) : coord + coord_t'(1);
      end else if (dec) begin
         coord_nxt = (coord == coord_t'(0)) ? BOARD_MAX : coord - coord_t'(1);
      end
`else
      if (inc && (coord != BOARD_MAX)) begin
         coord_nxt = coord + coord_t'(1);
      end else if (dec && (coord != coord_t'(0))) begin
         coord_nxt = coord - coord_t'(1);
      end
`endif
   end

endmodule

// File: rtl/cursor_select_ctrl.sv
// Board cursor navigation and source/destination move selection.
// Edge behaviour of the cursor is selected by the CURSOR_WRAP_EN macro.
module cursor_select_ctrl
   import chess_pkg::*;
#(
   parameter int INIT_ROW = 0,
   parameter int INIT_COL = 0
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       BtnU_pulse,
   input  logic       BtnD_pulse,
   input  logic       BtnL_pulse,
   input  logic       BtnR_pulse,
   input  logic       BtnC_pulse,
   input  logic       Sq_own_piece,
   input  logic       Move_ack,
   output logic [2:0] Cursor_row,
   output logic [2:0] Cursor_col,
   output logic       Sel_valid,
   output logic [2:0] Sel_row,
   output logic [2:0] Sel_col,
   output logic       Move_valid,
   output logic [2:0] Dst_row,
   output logic [2:0] Dst_col
);

   localparam coord_t INIT_R = coord_t'(INIT_ROW);
   localparam coord_t INIT_C = coord_t'(INIT_COL);

   sel_state_t state, state_nxt;
   coord_t     cur_row, cur_col, row_nxt, col_nxt;
   coord_t     sel_r, sel_c, dst_r, dst_c;
   logic       sel_ld, dst_ld, nav_en;
   logic       act_u, act_d, act_l, act_r;

   // C outranks every direction; among directions U > D > L > R.
   assign act_u  = BtnU_pulse & ~BtnC_pulse;
   assign act_d  = BtnD_pulse & ~BtnC_pulse & ~BtnU_pulse;
   assign act_l  = BtnL_pulse & ~BtnC_pulse & ~BtnU_pulse & ~BtnD_pulse;
   assign act_r  = BtnR_pulse & ~BtnC_pulse & ~BtnU_pulse & ~BtnD_pulse & ~BtnL_pulse;
   assign nav_en = (state != MOVE_PEND);

   cursor_axis_step u_row_step (
      .coord     (cur_row),
      .inc       (act_u & nav_en),
      .dec       (act_d & nav_en),
      .coord_nxt (row_nxt)
   );

   cursor_axis_step u_col_step (
      .coord     (cur_col),
      .inc       (act_r & nav_en),
      .dec       (act_l & nav_en),
      .coord_nxt (col_nxt)
   );

   always_comb begin
      state_nxt = state;
      sel_ld    = 1'b0;
      dst_ld    = 1'b0;
      unique case (state)
         SELECT_SRC: begin
            if (BtnC_pulse && Sq_own_piece) begin
               sel_ld    = 1'b1;
               state_nxt = SELECT_DST;
            end
         end
         SELECT_DST: begin
            if (BtnC_pulse) begin
               if ((cur_row == sel_r) && (cur_col == sel_c)) begin
                  state_nxt = SELECT_SRC;
               end else begin
                  dst_ld    = 1'b1;
                  state_nxt = MOVE_PEND;
               end
            end
         end
         MOVE_PEND: begin
            if (Move_ack) begin
               state_nxt = SELECT_SRC;
            end
         end
         default: state_nxt = SELECT_SRC;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state   <= SELECT_SRC;
         cur_row <= INIT_R;
         cur_col <= INIT_C;
         sel_r   <= '0;
         sel_c   <= '0;
         dst_r   <= '0;
         dst_c   <= '0;
      end else begin
         state   <= state_nxt;
         cur_row <= row_nxt;
         cur_col <= col_nxt;
         if (sel_ld) begin
            sel_r <= cur_row;
            sel_c <= cur_col;
         end
         if (dst_ld) begin
            dst_r <= cur_row;
            dst_c <= cur_col;
         end
      end
   end

   // Both valid flags are pure functions of the state, so reset drops them at once.
   assign Sel_valid  = (state != SELECT_SRC);
   assign Move_valid = (state == MOVE_PEND);
   assign Cursor_row = cur_row;
   assign Cursor_col = cur_col;
   assign Sel_row    = sel_r;
   assign Sel_col    = sel_c;
   assign Dst_row    = dst_r;
   assign Dst_col    = dst_c;

endmodule

// File: tb/tb_cursor_select_ctrl.sv
// Self-checking bench for cursor_select_ctrl: vector table, corner sequences, random vs model.
module tb_cursor_select_ctrl;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       BtnU_pulse = 1'b0, BtnD_pulse = 1'b0, BtnL_pulse = 1'b0;
   logic       BtnR_pulse = 1'b0, BtnC_pulse = 1'b0;
   logic       Sq_own_piece = 1'b0, Move_ack = 1'b0;
   logic [2:0] Cursor_row, Cursor_col, Sel_row, Sel_col, Dst_row, Dst_col;
   logic       Sel_valid, Move_valid;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_row, m_col, m_sr, m_sc, m_dr, m_dc;
   bit m_selected, m_pending;

   cursor_select_ctrl #(.INIT_ROW(0), .INIT_COL(0)) dut (
      .CLK          (CLK),
      .RESET_N      (RESET_N),
      .BtnU_pulse   (BtnU_pulse),
      .BtnD_pulse   (BtnD_pulse),
      .BtnL_pulse   (BtnL_pulse),
      .BtnR_pulse   (BtnR_pulse),
      .BtnC_pulse   (BtnC_pulse),
      .Sq_own_piece (Sq_own_piece),
      .Move_ack     (Move_ack),
      .Cursor_row   (Cursor_row),
      .Cursor_col   (Cursor_col),
      .Sel_valid    (Sel_valid),
      .Sel_row      (Sel_row),
      .Sel_col      (Sel_col),
      .Move_valid   (Move_valid),
      .Dst_row      (Dst_row),
      .Dst_col      (Dst_col)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic u, d, l, r, c, own, ack;
      int   er, ec;
      logic esv, emv;
   } vec_t;

   vec_t tbl[12];

   function automatic vec_t mk(input logic [6:0] b, input int er, input int ec,
                               input logic esv, input logic emv);
      vec_t v;
      {v.u, v.d, v.l, v.r, v.c, v.own, v.ack} = b;
      v.er = er; v.ec = ec; v.esv = esv; v.emv = emv;
      return v;
   endfunction

   task automatic chk(input string name, input logic [2:0] act, input int exp);
      checks++;
      if (act !== 3'(exp)) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int move1(input int v, input int delta);
`ifdef CURSOR_WRAP_EN
      return (v + delta + 8) % 8;
`else
      if (v + delta < 0) return 0;
      if (v + delta > 7) return 7;
      return v + delta;
`endif
   endfunction

   function automatic void model_reset();
      m_row = 0; m_col = 0; m_sr = 0; m_sc = 0; m_dr = 0; m_dc = 0;
      m_selected = 0; m_pending = 0;
   endfunction

   function automatic void model_step(input logic u, d, l, r, c, own, ack);
      if (m_pending) begin
         if (ack) begin
            m_pending = 0;
            m_selected = 0;
         end
      end else if (c) begin
         if (!m_selected) begin
            if (own) begin
               m_selected = 1; m_sr = m_row; m_sc = m_col;
            end
         end else if (m_row == m_sr && m_col == m_sc) begin
            m_selected = 0;
         end else begin
            m_dr = m_row; m_dc = m_col; m_pending = 1;
         end
      end
      else if (u) m_row = move1(m_row, 1);
      else if (d) m_row = move1(m_row, -1);
      else if (l) m_col = move1(m_col, -1);
      else if (r) m_col = move1(m_col, 1);
   endfunction

   task automatic check_model(input string tag);
      chk({tag, ".row"}, Cursor_row, m_row);
      chk({tag, ".col"}, Cursor_col, m_col);
      chk({tag, ".sel_valid"}, {2'b00, Sel_valid}, int'(m_selected));
      chk({tag, ".move_valid"}, {2'b00, Move_valid}, int'(m_pending));
      if (m_selected) begin
         chk({tag, ".sel_row"}, Sel_row, m_sr);
         chk({tag, ".sel_col"}, Sel_col, m_sc);
      end
      if (m_pending) begin
         chk({tag, ".dst_row"}, Dst_row, m_dr);
         chk({tag, ".dst_col"}, Dst_col, m_dc);
      end
   endtask

   // Apply one cycle of inputs, advance the model, and leave sampling point #1 after the edge.
   task automatic cyc(input logic u, d, l, r, c, own, ack);
      BtnU_pulse = u; BtnD_pulse = d; BtnL_pulse = l; BtnR_pulse = r; BtnC_pulse = c;
      Sq_own_piece = own; Move_ack = ack;
      model_step(u, d, l, r, c, own, ack);
      @(posedge CLK); #1;
      BtnU_pulse = 0; BtnD_pulse = 0; BtnL_pulse = 0; BtnR_pulse = 0; BtnC_pulse = 0;
      Move_ack = 0;
   endtask

   task automatic do_reset();
      RESET_N = 0;
      model_reset();
      @(posedge CLK); @(posedge CLK); #1;
      RESET_N = 1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, ".row"}, Cursor_row, 0);
      chk({tag, ".col"}, Cursor_col, 0);
      chk({tag, ".sel_valid"}, {2'b00, Sel_valid}, 0);
      chk({tag, ".move_valid"}, {2'b00, Move_valid}, 0);
      chk({tag, ".sel_row"}, Sel_row, 0);
      chk({tag, ".sel_col"}, Sel_col, 0);
      chk({tag, ".dst_row"}, Dst_row, 0);
      chk({tag, ".dst_col"}, Dst_col, 0);
   endtask

   initial begin
      // bits: u d l r c own ack
      tbl[0]  = mk(7'b1000000, 1, 0, 1'b0, 1'b0);
      tbl[1]  = mk(7'b1000000, 2, 0, 1'b0, 1'b0);
      tbl[2]  = mk(7'b1000000, 3, 0, 1'b0, 1'b0);
      tbl[3]  = mk(7'b0001000, 3, 1, 1'b0, 1'b0);
      tbl[4]  = mk(7'b0001000, 3, 2, 1'b0, 1'b0);
      tbl[5]  = mk(7'b0100000, 2, 2, 1'b0, 1'b0);
      tbl[6]  = mk(7'b1000110, 2, 2, 1'b1, 1'b0);
      tbl[7]  = mk(7'b1000000, 3, 2, 1'b1, 1'b0);
      tbl[8]  = mk(7'b0110000, 2, 2, 1'b1, 1'b0);
      tbl[9]  = mk(7'b0000100, 2, 2, 1'b0, 1'b0);
      tbl[10] = mk(7'b0000100, 2, 2, 1'b0, 1'b0);
      tbl[11] = mk(7'b0011000, 2, 1, 1'b0, 1'b0);

      do_reset();
      check_reset_vals("reset");

      for (int i = 0; i < 12; i++) begin
         cyc(tbl[i].u, tbl[i].d, tbl[i].l, tbl[i].r, tbl[i].c, tbl[i].own, tbl[i].ack);
         chk($sformatf("vec%0d.row", i), Cursor_row, tbl[i].er);
         chk($sformatf("vec%0d.col", i), Cursor_col, tbl[i].ec);
         chk($sformatf("vec%0d.sel_valid", i), {2'b00, Sel_valid}, int'(tbl[i].esv));
         chk($sformatf("vec%0d.move_valid", i), {2'b00, Move_valid}, int'(tbl[i].emv));
         if (i == 6) begin
            chk("vec6.sel_row", Sel_row, 2);
            chk("vec6.sel_col", Sel_col, 2);
         end
      end

      // Edge behaviour at (7,7)
      do_reset();
      for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 0, 0, 0);
      chk("edge.pre_row", Cursor_row, 7);
      chk("edge.pre_col", Cursor_col, 7);
      cyc(1, 0, 0, 0, 0, 0, 0);
`ifdef CURSOR_WRAP_EN
      chk("edge.u_row", Cursor_row, 0);
`else
      chk("edge.u_row", Cursor_row, 7);
`endif
      chk("edge.u_col", Cursor_col, 7);

      // Cancel and no-piece select at (1,4)
      do_reset();
      cyc(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 1, 0);
      chk("cancel.sel_valid0", {2'b00, Sel_valid}, 1);
      chk("cancel.sel_row", Sel_row, 1);
      chk("cancel.sel_col", Sel_col, 4);
      cyc(0, 0, 0, 0, 1, 1, 0);
      chk("cancel.sel_valid1", {2'b00, Sel_valid}, 0);
      chk("cancel.move_valid", {2'b00, Move_valid}, 0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("nopiece.sel_valid", {2'b00, Sel_valid}, 0);
      check_model("nopiece");

      // Full move (1,4) -> (3,4), pulses while pending, ack with a coincident pulse
      cyc(0, 0, 0, 0, 1, 1, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("move.move_valid", {2'b00, Move_valid}, 1);
      chk("move.dst_row", Dst_row, 3);
      chk("move.dst_col", Dst_col, 4);
      chk("move.sel_valid", {2'b00, Sel_valid}, 1);
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 1, 0);
      chk("pend.row", Cursor_row, 3);
      chk("pend.col", Cursor_col, 4);
      chk("pend.move_valid", {2'b00, Move_valid}, 1);
      chk("pend.sel_row", Sel_row, 1);
      cyc(1, 0, 0, 0, 0, 0, 1);
      chk("ack.move_valid", {2'b00, Move_valid}, 0);
      chk("ack.sel_valid", {2'b00, Sel_valid}, 0);
      chk("ack.row", Cursor_row, 3);
      chk("ack.col", Cursor_col, 4);
      cyc(0, 0, 0, 0, 0, 0, 1);
      check_model("ack_outside");

      // Asynchronous reset while a move is pending
      cyc(0, 0, 0, 0, 1, 1, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("arst.pre_move_valid", {2'b00, Move_valid}, 1);
      #2 RESET_N = 0;
      #1 check_reset_vals("arst");
      model_reset();
      @(posedge CLK); #1;
      RESET_N = 1;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 1);
         chk($sformatf("arst.post%0d.move_valid", i), {2'b00, Move_valid}, 0);
         chk($sformatf("arst.post%0d.sel_valid", i), {2'b00, Sel_valid}, 0);
      end

      // Randomized traffic against the model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         logic u, d, l, r, c, own, ack;
         u = ($urandom_range(0, 3) == 0);
         d = ($urandom_range(0, 3) == 0);
         l = ($urandom_range(0, 3) == 0);
         r = ($urandom_range(0, 3) == 0);
         c = ($urandom_range(0, 4) == 0);
         own = ($urandom_range(0, 1) == 1);
         ack = ($urandom_range(0, 5) == 0);
         cyc(u, d, l, r, c, own, ack);
         check_model($sformatf("rnd%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
